// File: rtl/pio_irq_gen.sv
// Avalon-MM general-purpose I/O port with per-bit direction, atomic set/clear,
// synchronised inputs, edge capture and a maskable level interrupt.
module pio_irq_gen #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = '0,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [2:0] ArmMax = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [2:0]       arm_q;
    logic [31:0]      rd_d;
    logic [WIDTH-1:0] wd, sync_last, edge_det, clr;
    logic             wr;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign sync_last = sync_q[SYNC_STAGES-1];

    if (WIDTH < 32) begin : g_unused_wd
        logic unused_wd;
        assign unused_wd = ^writedata[31:WIDTH];
    end

    always_comb begin
        edge_det = '0;
        if (arm_q == ArmMax) begin
            case (EDGE_TYPE)
                0:       edge_det = sync_last & ~prev_q;
                1:       edge_det = ~sync_last & prev_q;
                default: edge_det = sync_last ^ prev_q;
            endcase
        end
    end

    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        clr    = '0;
        if (wr) begin
            case (address)
                3'd0:    data_d = wd;
                3'd1:    dir_d  = wd;
                3'd2:    mask_d = wd;
                3'd3:    clr    = wd;
                3'd4:    data_d = data_q | wd;
                3'd5:    data_d = data_q & ~wd;
                default: ;
            endcase
        end
        // A new edge wins over a simultaneous W1C clear of the same bit.
        cap_d = (cap_q & ~clr) | edge_det;
    end

    always_comb begin
        rd_d = '0;
        case (address)
            3'd0:    rd_d[WIDTH-1:0] = (data_q & dir_q) | (sync_last & ~dir_q);
            3'd1:    rd_d[WIDTH-1:0] = dir_q;
            3'd2:    rd_d[WIDTH-1:0] = mask_q;
            3'd3:    rd_d[WIDTH-1:0] = cap_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE[WIDTH-1:0];
            dir_q    <= '0;
            mask_q   <= '0;
            cap_q    <= '0;
            prev_q   <= '0;
            arm_q    <= '0;
            readdata <= '0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
            data_q   <= data_d;
            dir_q    <= dir_d;
            mask_q   <= mask_d;
            cap_q    <= cap_d;
            prev_q   <= sync_last;
            readdata <= rd_d;
            if (arm_q != ArmMax) arm_q <= arm_q + 3'd1;
            sync_q[0] <= in_port;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign out_port = data_q;
    assign oe       = dir_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_irq_gen.sv
// Self-checking bench for pio_irq_gen: bus reads go through a scoreboard queue,
// pin and irq outputs are checked directly.
module tb_pio_irq_gen;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  oe;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    pio_irq_gen #(
        .WIDTH      (8),
        .RESET_VALUE(32'h0),
        .EDGE_TYPE  (0),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .oe        (oe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Expected value is queued when the address is driven and retired when readdata updates.
    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
        address = a;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        tick(1);
        check_eq(tag_q.pop_front(), readdata, exp_q.pop_front());
    endtask

    initial begin
        clk        = 1'b0;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'hFF;

        tick(3);
        check_eq("rst_out_port", 32'(out_port), 32'h00);
        check_eq("rst_oe", 32'(oe), 32'h00);
        check_eq("rst_irq", 32'(irq), 32'h0);
        check_eq("rst_readdata", readdata, 32'h0);
        reset_n = 1'b1;

        // Pins high at release must not be captured while the arm counter runs.
        for (int i = 0; i < 10; i++) begin
            bus_read(3'd3, 32'h0, "arm_ecap");
            check_eq("arm_irq", 32'(irq), 32'h0);
        end
        bus_read(3'd0, 32'hFF, "rst_data_sync");
        bus_read(3'd1, 32'h00, "rst_dir");
        bus_read(3'd2, 32'h00, "rst_mask");
        for (int a = 4; a < 8; a++) bus_read(3'(a), 32'h0, "rst_rsvd_or_wo");

        // Set / clear
        bus_write(3'd1, 32'hFF);
        check_eq("dir_oe", 32'(oe), 32'hFF);
        bus_write(3'd0, 32'hFFFF_FF0F);
        check_eq("data_wr", 32'(out_port), 32'h0F);
        bus_write(3'd4, 32'h30);
        check_eq("outset", 32'(out_port), 32'h3F);
        bus_write(3'd5, 32'h05);
        check_eq("outclear", 32'(out_port), 32'h3A);
        bus_read(3'd0, 32'h3A, "data_rd_out");

        // Mixed direction
        bus_write(3'd1, 32'hF0);
        bus_write(3'd0, 32'hA5);
        in_port = 8'h3C;
        tick(3);
        bus_read(3'd0, 32'hAC, "data_rd_mixed");
        bus_read(3'd3, 32'h00, "falls_no_cap");

        // Rising edge on bit 0 -> irq after SYNC_STAGES+1 edges
        bus_write(3'd2, 32'h01);
        in_port = 8'h3D;
        tick(1);
        check_eq("irq_lat_k", 32'(irq), 32'h0);
        tick(1);
        check_eq("irq_lat_k1", 32'(irq), 32'h0);
        tick(1);
        check_eq("irq_lat_k2", 32'(irq), 32'h1);
        bus_read(3'd3, 32'h01, "ecap_rise");
        bus_write(3'd3, 32'h01);
        check_eq("irq_w1c", 32'(irq), 32'h0);

        // Falling edge ignored, then rising edge collides with a W1C clear
        in_port = 8'h39;
        tick(4);
        bus_read(3'd3, 32'h00, "fall_ignored");
        in_port = 8'h3D;
        tick(2);
        bus_write(3'd3, 32'h04);
        bus_read(3'd3, 32'h04, "set_wins");
        check_eq("unmasked_irq", 32'(irq), 32'h0);
        bus_write(3'd3, 32'h04);
        bus_read(3'd3, 32'h00, "w1c_clear");

        // Mask
        bus_write(3'd2, 32'h7F);
        in_port = 8'hBD;
        tick(4);
        bus_read(3'd3, 32'h80, "ecap_bit7");
        check_eq("mask_off_irq", 32'(irq), 32'h0);
        bus_write(3'd2, 32'hFF);
        check_eq("mask_on_irq", 32'(irq), 32'h1);
        bus_read(3'd2, 32'hFF, "mask_rd");

        // Reserved writes ignored
        bus_write(3'd6, 32'hFF);
        bus_write(3'd7, 32'h00);
        check_eq("rsvd_wr", 32'(out_port), 32'hA5);
        bus_read(3'd6, 32'h0, "rsvd_rd");

        // Reset asserted mid-write clears state immediately
        address    = 3'd0;
        writedata  = 32'h55;
        chipselect = 1'b1;
        write_n    = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_eq("midrst_out_port", 32'(out_port), 32'h00);
        check_eq("midrst_oe", 32'(oe), 32'h00);
        check_eq("midrst_irq", 32'(irq), 32'h0);
        check_eq("midrst_readdata", readdata, 32'h0);
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        check_eq("midrst_hold", 32'(out_port), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
